// File: rtl/fetch_pkg.sv
// ---------------------------------------------------------------------------
// fetch_pkg
// Shared definitions for the instruction fetch slice: default datapath width,
// default reset PC, the fetch FSM state encoding, and a canonical NOP word
// that benches can use as filler memory content.
// No ports (package).
// ---------------------------------------------------------------------------
package fetch_pkg;

  localparam int          DEFAULT_DWIDTH   = 32;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
  localparam logic [31:0] INSTR_NOP        = 32'h0000_0013;

  typedef enum logic {
    RESET_WAIT = 1'b0,
    RUN        = 1'b1
  } fetch_state_e;

endpackage

// File: rtl/instruction_fetch_if.sv
// ---------------------------------------------------------------------------
// instruction_fetch_if
// Bundles the fetch unit's memory, redirect and decode-side handshake signals.
//   addressOut     : byte address driven to the instruction memory
//   instructionIn  : registered memory read data (one cycle after address)
//   redirectValid  : branch/jump redirect request
//   redirectTarget : redirect byte address
//   readyIn        : decode accepts the current output
//   validOut       : instructionOut/pcOut hold a fetched instruction
//   instructionOut : fetched instruction
//   pcOut          : byte address of instructionOut
//   misalignOut    : one-cycle pulse after a misaligned redirect target
// master = fetch unit, slave = memory/decode/branch environment.
// ---------------------------------------------------------------------------
interface instruction_fetch_if #(
  parameter int DWIDTH = fetch_pkg::DEFAULT_DWIDTH
);

  logic [DWIDTH-1:0] addressOut;
  logic [DWIDTH-1:0] instructionIn;
  logic              redirectValid;
  logic [DWIDTH-1:0] redirectTarget;
  logic              readyIn;
  logic              validOut;
  logic [DWIDTH-1:0] instructionOut;
  logic [DWIDTH-1:0] pcOut;
  logic              misalignOut;

  modport master (
    output addressOut, validOut, instructionOut, pcOut, misalignOut,
    input  instructionIn, redirectValid, redirectTarget, readyIn
  );

  modport slave (
    input  addressOut, validOut, instructionOut, pcOut, misalignOut,
    output instructionIn, redirectValid, redirectTarget, readyIn
  );

endinterface

// File: rtl/fetch_buffer.sv
// ---------------------------------------------------------------------------
// fetch_buffer
// Two-entry in-order buffer holding fetched instruction/PC pairs between the
// memory response and the decode handshake.
//   clk, reset  : clock, synchronous active-high reset (empties the buffer)
//   flush_i     : drop every entry (takes priority over push/pop)
//   push_i      : append pushData_i/pushPc_i
//   pop_i       : remove the head entry
//   count_o     : number of valid entries (0..2)
//   headData_o  : head instruction, zero when empty
//   headPc_o    : head PC, zero when empty
// ---------------------------------------------------------------------------
module fetch_buffer #(
  parameter int DWIDTH = fetch_pkg::DEFAULT_DWIDTH
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush_i,
  input  logic              push_i,
  input  logic              pop_i,
  input  logic [DWIDTH-1:0] pushData_i,
  input  logic [DWIDTH-1:0] pushPc_i,
  output logic [1:0]        count_o,
  output logic [DWIDTH-1:0] headData_o,
  output logic [DWIDTH-1:0] headPc_o
);

  logic [DWIDTH-1:0] data0_q, data0_d, pc0_q, pc0_d;
  logic [DWIDTH-1:0] data1_q, data1_d, pc1_q, pc1_d;
  logic [1:0]        count_q, count_d;

  // Entry 0 is always the head. A pop shifts entry 1 down; a push lands in
  // the first free slot, or in slot 1 behind a shifted head when both happen
  // with the buffer full.
  always_comb begin
    data0_d = data0_q;
    pc0_d   = pc0_q;
    data1_d = data1_q;
    pc1_d   = pc1_q;
    count_d = count_q;
    if (flush_i) begin
      count_d = 2'd0;
    end else begin
      case ({push_i, pop_i})
        2'b01: begin
          data0_d = data1_q;
          pc0_d   = pc1_q;
          count_d = count_q - 2'd1;
        end
        2'b10: begin
          if (count_q == 2'd0) begin
            data0_d = pushData_i;
            pc0_d   = pushPc_i;
          end else begin
            data1_d = pushData_i;
            pc1_d   = pushPc_i;
          end
          count_d = count_q + 2'd1;
        end
        2'b11: begin
          if (count_q == 2'd2) begin
            data0_d = data1_q;
            pc0_d   = pc1_q;
            data1_d = pushData_i;
            pc1_d   = pushPc_i;
          end else begin
            data0_d = pushData_i;
            pc0_d   = pushPc_i;
          end
        end
        default: ;
      endcase
    end
  end

  // Storage registers; reset clears everything so the head reads as zero.
  always_ff @(posedge clk) begin
    if (reset) begin
      data0_q <= '0;
      pc0_q   <= '0;
      data1_q <= '0;
      pc1_q   <= '0;
      count_q <= 2'd0;
    end else begin
      data0_q <= data0_d;
      pc0_q   <= pc0_d;
      data1_q <= data1_d;
      pc1_q   <= pc1_d;
      count_q <= count_d;
    end
  end

  assign count_o    = count_q;
  assign headData_o = (count_q != 2'd0) ? data0_q : '0;
  assign headPc_o   = (count_q != 2'd0) ? pc0_q : '0;

endmodule

// File: rtl/instruction_fetch.sv
// ---------------------------------------------------------------------------
// instruction_fetch
// Sequential instruction fetch front end with redirect support. Issues word
// addresses to a registered-read instruction memory, tracks the one request
// in flight, and feeds a two-entry buffer that drives the decode handshake.
//   clk   : clock, all state updates on the rising edge
//   reset : synchronous active-high reset
//   bus   : instruction_fetch_if.master (memory, redirect, decode signals)
// Parameters: DWIDTH (address/instruction width), RESET_PC (first fetch).
// ---------------------------------------------------------------------------
module instruction_fetch #(
  parameter int                DWIDTH   = fetch_pkg::DEFAULT_DWIDTH,
  parameter logic [DWIDTH-1:0] RESET_PC = DWIDTH'(fetch_pkg::DEFAULT_RESET_PC)
) (
  input logic                 clk,
  input logic                 reset,
  instruction_fetch_if.master bus
);

  import fetch_pkg::*;

  fetch_state_e      state_q, state_d;
  logic [DWIDTH-1:0] fetchPc_q, fetchPc_d;
  logic [DWIDTH-1:0] inFlightPc_q, inFlightPc_d;
  logic              inFlightValid_q, inFlightValid_d;
  logic              misalign_q, misalign_d;

  logic [1:0]        bufferCount;
  logic [DWIDTH-1:0] headData;
  logic [DWIDTH-1:0] headPc;
  logic              pop;
  logic              push;
  logic [2:0]        occupancy;
  logic [DWIDTH-1:0] alignedTarget;

  assign pop           = (bufferCount != 2'd0) && bus.readyIn;
  // A redirect discards the response arriving in the same cycle.
  assign push          = inFlightValid_q && !bus.redirectValid;
  // Slots that will be spoken for after this cycle; a new request is only
  // safe when its response is guaranteed a free slot.
  assign occupancy     = {1'b0, bufferCount} + {2'b00, inFlightValid_q} - {2'b00, pop};
  assign alignedTarget = {bus.redirectTarget[DWIDTH-1:2], 2'b00};

  // Next-state logic. RESET_WAIT idles one cycle while memory loads, but
  // still latches a redirect target. In RUN a redirect wins over issuing.
  always_comb begin
    state_d         = state_q;
    fetchPc_d       = fetchPc_q;
    inFlightValid_d = 1'b0;
    inFlightPc_d    = inFlightPc_q;
    misalign_d      = bus.redirectValid && (bus.redirectTarget[1:0] != 2'b00);
    case (state_q)
      RESET_WAIT: begin
        state_d = RUN;
        if (bus.redirectValid) fetchPc_d = alignedTarget;
      end
      RUN: begin
        if (bus.redirectValid) begin
          fetchPc_d = alignedTarget;
        end else if (occupancy < 3'd2) begin
          inFlightValid_d = 1'b1;
          inFlightPc_d    = fetchPc_q;
          fetchPc_d       = fetchPc_q + DWIDTH'(4);
        end
      end
      default: state_d = RESET_WAIT;
    endcase
  end

  // State registers with synchronous reset back to the first fetch address.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q         <= RESET_WAIT;
      fetchPc_q       <= RESET_PC;
      inFlightValid_q <= 1'b0;
      inFlightPc_q    <= '0;
      misalign_q      <= 1'b0;
    end else begin
      state_q         <= state_d;
      fetchPc_q       <= fetchPc_d;
      inFlightValid_q <= inFlightValid_d;
      inFlightPc_q    <= inFlightPc_d;
      misalign_q      <= misalign_d;
    end
  end

  fetch_buffer #(.DWIDTH(DWIDTH)) u_buffer (
    .clk        (clk),
    .reset      (reset),
    .flush_i    (bus.redirectValid),
    .push_i     (push),
    .pop_i      (pop),
    .pushData_i (bus.instructionIn),
    .pushPc_i   (inFlightPc_q),
    .count_o    (bufferCount),
    .headData_o (headData),
    .headPc_o   (headPc)
  );

  assign bus.addressOut     = fetchPc_q;
  assign bus.validOut       = (bufferCount != 2'd0);
  assign bus.instructionOut = headData;
  assign bus.pcOut          = headPc;
  assign bus.misalignOut    = misalign_q;

endmodule

// File: doc/instruction_fetch.md
INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

Interface
REQ-001 Parameter DWIDTH, default 32: instruction and address width.
REQ-002 Parameter RESET_PC, default 32'h0000_0000: first fetch address after reset.
REQ-003 Port clk, input, 1: the single clock; all state updates on its rising edge.
REQ-004 Port reset, input, 1: synchronous, active-high reset.
REQ-005 Port addressOut, output, DWIDTH: byte address presented to the instruction memory addressIn; bits [1:0] always 0.
REQ-006 Port instructionIn, input, DWIDTH: memory data; valid one cycle after the address was presented (registered read).
REQ-007 Port redirectValid, input, 1: branch/jump redirect request.
REQ-008 Port redirectTarget, input, DWIDTH: redirect byte address.
REQ-009 Port readyIn, input, 1: decode stage accepts the current output.
REQ-010 Port validOut, output, 1: instructionOut/pcOut hold a valid fetched instruction.
REQ-011 Port instructionOut, output, DWIDTH: fetched instruction.
REQ-012 Port pcOut, output, DWIDTH: byte address of instructionOut.
REQ-013 Port misalignOut, output, 1: one-cycle pulse when a redirect target had bits [1:0] nonzero.

Function
REQ-014 States: RESET_WAIT, RUN; reset enters RESET_WAIT; RESET_WAIT -> RUN unconditionally next cycle; no fetch is issued in RESET_WAIT, since memory contents load at reset.
REQ-015 Registers: fetchPc (drives addressOut), inFlightValid, inFlightPc, 2-entry output buffer (head drives outputs).
REQ-016 Handshake: an entry is popped in a cycle where validOut=1 and readyIn=1; validOut/instructionOut/pcOut stay stable while validOut=1 and readyIn=0.
REQ-017 Issue rule (RUN, no redirect): issue at addressOut iff bufferCount + inFlightValid - pop < 2; on issue, next inFlightValid=1, inFlightPc=fetchPc, fetchPc+=4; else addressOut holds and inFlightValid=0.
REQ-018 Response: when inFlightValid=1, instructionIn is pushed into the buffer with inFlightPc in that cycle; the issue rule guarantees no overflow.
REQ-019 Latency: address issued in cycle t -> entry pushed at end of t+1 -> validOut=1 in cycle t+2 when the buffer was empty.
REQ-020 Throughput: with readyIn held 1, one instruction per cycle in steady state.
REQ-021 Redirect in cycle t: buffer flushed, inFlightValid cleared, instructionIn of cycle t discarded, fetchPc=redirectTarget with [1:0] forced to 0; addressOut=target in t+1, validOut with target in t+3; a pop in cycle t is still honoured.
REQ-022 Redirect while another redirect is in progress: the newest redirect wins; no older-path instruction is ever output after a redirect.
REQ-023 Misaligned redirect: misalignOut=1 in cycle t+1 only; fetch continues from the aligned target.
REQ-024 PC arithmetic is modulo 2^DWIDTH: 32'hFFFF_FFFC + 4 wraps to 0 without error.
REQ-025 redirectValid in RESET_WAIT is honoured: fetchPc=target, RUN entered as normal.

Reset
REQ-026 While reset=1 at an edge: state=RESET_WAIT, fetchPc=RESET_PC, inFlightValid=0, buffer emptied; outputs next cycle validOut=0, instructionOut=0, pcOut=0, misalignOut=0, addressOut=RESET_PC.
REQ-027 Reset mid-operation discards all buffered and in-flight instructions; the first fetch after reset is RESET_PC.

Structure
REQ-028 Shared package fetch_pkg holds DWIDTH, RESET_PC default, state encoding (RESET_WAIT, RUN), and constant INSTR_NOP = 32'h0000_0013 for the bench.
REQ-029 The 2-entry buffer is sub-module fetch_buffer (push/pop/flush, count, head data+pc); the remaining logic stays in instruction_fetch.

Verification
REQ-030 Reset release, readyIn=1, memory words 0..3 = A,B,C,D -> validOut first at cycle 3 after reset falls; pcOut 0,4,8,12 with A,B,C,D, one per cycle.
REQ-031 readyIn=0 for 5 cycles mid-stream -> outputs frozen; bufferCount=2; addressOut stalls; after release no instruction is lost or duplicated.
REQ-032 Redirect to 32'h40 with 2 buffered and 1 in flight -> none of those 3 are output; next validOut has pcOut=32'h40 three cycles later.
REQ-033 redirectTarget=32'h42 -> misalignOut pulse once; pcOut=32'h40.
REQ-034 RESET_PC=32'hFFFF_FFF8 -> pcOut sequence FFFF_FFF8, FFFF_FFFC, 0000_0000.
REQ-035 reset asserted for 1 cycle during stall with full buffer -> validOut=0 next cycle; refetch begins at RESET_PC.
